// File: rtl/cursor_command_decoder_if.sv
// ============================================================================
// Module      : cursor_command_decoder_if
// Description : Byte stream, cursor register and screen-write bundle for the
//               cursor command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cursor_command_decoder_if #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7
);
    logic [7:0]          data;
    logic                valid;
    logic                ready;
    logic [ROW_BITS-1:0] cur_row;
    logic [COL_BITS-1:0] cur_col;
    logic [ROW_BITS-1:0] new_row;
    logic                row_wen;
    logic [COL_BITS-1:0] new_col;
    logic                col_wen;
    logic [ROW_BITS-1:0] wr_row;
    logic [COL_BITS-1:0] wr_col;
    logic [7:0]          char_out;
    logic                char_wen;
    logic                scroll;

    modport master (
        output data, valid, cur_row, cur_col,
        input  ready, new_row, row_wen, new_col, col_wen,
               wr_row, wr_col, char_out, char_wen, scroll
    );

    modport slave (
        input  data, valid, cur_row, cur_col,
        output ready, new_row, row_wen, new_col, col_wen,
               wr_row, wr_col, char_out, char_wen, scroll
    );
endinterface

`default_nettype wire

// File: rtl/cursor_command_decoder.sv
// ============================================================================
// Module      : cursor_command_decoder
// Description : VT52-style byte decoder driving cursor registers, screen
//               writes, erase sweeps and scroll requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cursor_command_decoder #(
    parameter int ROWS     = 24,
    parameter int COLS     = 80,
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7
) (
    input  wire logic                 clk,
    input  wire logic                 clr,
    cursor_command_decoder_if.slave   bus
);

    localparam logic [ROW_BITS-1:0] C_ROW_LAST = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] C_COL_LAST = COL_BITS'(COLS - 1);
    localparam logic [COL_BITS-1:0] C_TAB_LIM  = COL_BITS'(COLS - 8);
    localparam logic [COL_BITS-1:0] C_TAB_STEP = COL_BITS'(8);
    localparam logic [7:0]          C_ROWS_B   = 8'(ROWS);
    localparam logic [7:0]          C_COLS_B   = 8'(COLS);

    typedef enum logic [2:0] {
        ST_NORMAL = 3'd0,
        ST_ESC    = 3'd1,
        ST_YROW   = 3'd2,
        ST_YCOL   = 3'd3,
        ST_ERASE  = 3'd4
    } state_t;

    state_t              r_state, w_state;
    logic                r_ready, w_ready;
    logic [ROW_BITS-1:0] r_new_row, w_new_row, r_wr_row, w_wr_row;
    logic [COL_BITS-1:0] r_new_col, w_new_col, r_wr_col, w_wr_col;
    logic                r_row_wen, w_row_wen, r_col_wen, w_col_wen;
    logic                r_char_wen, w_char_wen, r_scroll, w_scroll;
    logic [7:0]          r_char_out, w_char_out;
    logic [ROW_BITS-1:0] r_er_row, w_er_row, r_y_row, w_y_row;
    logic [COL_BITS-1:0] r_er_col, w_er_col;
    logic                r_er_screen, w_er_screen, r_y_ok, w_y_ok;

    logic                w_accept, w_do_erase, w_src_screen, w_src_last, w_data_ge;
    logic [7:0]          w_diff;
    logic [ROW_BITS-1:0] w_src_row;
    logic [COL_BITS-1:0] w_src_col;

    assign w_accept  = bus.valid && r_ready;
    assign w_diff    = bus.data - 8'h20;
    assign w_data_ge = (bus.data >= 8'h20);

    // Erase writes come from the live cursor on the command byte, then from
    // the sweep pointer while in ERASE.
    assign w_src_row    = (r_state == ST_ERASE) ? r_er_row    : bus.cur_row;
    assign w_src_col    = (r_state == ST_ERASE) ? r_er_col    : bus.cur_col;
    assign w_src_screen = (r_state == ST_ERASE) ? r_er_screen : (bus.data == 8'h4A);
    assign w_src_last   = (w_src_col == C_COL_LAST) &&
                          (!w_src_screen || (w_src_row == C_ROW_LAST));

    always_comb begin
        w_state     = r_state;
        w_new_row   = r_new_row;
        w_new_col   = r_new_col;
        w_wr_row    = r_wr_row;
        w_wr_col    = r_wr_col;
        w_char_out  = r_char_out;
        w_row_wen   = 1'b0;
        w_col_wen   = 1'b0;
        w_char_wen  = 1'b0;
        w_scroll    = 1'b0;
        w_er_row    = r_er_row;
        w_er_col    = r_er_col;
        w_er_screen = r_er_screen;
        w_y_row     = r_y_row;
        w_y_ok      = r_y_ok;
        w_do_erase  = 1'b0;

        case (r_state)
            ST_NORMAL: if (w_accept) begin
                if (w_data_ge && bus.data <= 8'h7E) begin
                    w_char_wen = 1'b1;
                    w_char_out = bus.data;
                    w_wr_row   = bus.cur_row;
                    w_wr_col   = bus.cur_col;
                    if (bus.cur_col < C_COL_LAST) begin
                        w_new_col = bus.cur_col + 1'b1;
                        w_col_wen = 1'b1;
                    end
                end else begin
                    case (bus.data)
                        8'h0D: begin
                            w_new_col = '0;
                            w_col_wen = 1'b1;
                        end
                        8'h0A: begin
                            if (bus.cur_row < C_ROW_LAST) begin
                                w_new_row = bus.cur_row + 1'b1;
                                w_row_wen = 1'b1;
                            end else begin
                                w_scroll = 1'b1;
                            end
                        end
                        8'h08: if (bus.cur_col != '0) begin
                            w_new_col = bus.cur_col - 1'b1;
                            w_col_wen = 1'b1;
                        end
                        8'h09: begin
                            if (bus.cur_col < C_TAB_LIM) begin
                                w_new_col = {bus.cur_col[COL_BITS-1:3], 3'b000} + C_TAB_STEP;
                                w_col_wen = 1'b1;
                            end else if (bus.cur_col < C_COL_LAST) begin
                                w_new_col = bus.cur_col + 1'b1;
                                w_col_wen = 1'b1;
                            end
                        end
                        8'h1B:   w_state = ST_ESC;
                        default: ;
                    endcase
                end
            end
            ST_ESC: if (w_accept) begin
                w_state = ST_NORMAL;
                case (bus.data)
                    8'h41: if (bus.cur_row != '0) begin
                        w_new_row = bus.cur_row - 1'b1;
                        w_row_wen = 1'b1;
                    end
                    8'h42: if (bus.cur_row < C_ROW_LAST) begin
                        w_new_row = bus.cur_row + 1'b1;
                        w_row_wen = 1'b1;
                    end
                    8'h43: if (bus.cur_col < C_COL_LAST) begin
                        w_new_col = bus.cur_col + 1'b1;
                        w_col_wen = 1'b1;
                    end
                    8'h44: if (bus.cur_col != '0) begin
                        w_new_col = bus.cur_col - 1'b1;
                        w_col_wen = 1'b1;
                    end
                    8'h48: begin
                        w_new_row = '0;
                        w_new_col = '0;
                        w_row_wen = 1'b1;
                        w_col_wen = 1'b1;
                    end
                    8'h59:        w_state    = ST_YROW;
                    8'h4A, 8'h4B: w_do_erase = 1'b1;
                    default: ;
                endcase
            end
            ST_YROW: if (w_accept) begin
                w_y_row = w_diff[ROW_BITS-1:0];
                w_y_ok  = w_data_ge && (w_diff < C_ROWS_B);
                w_state = ST_YCOL;
            end
            ST_YCOL: if (w_accept) begin
                w_state = ST_NORMAL;
                if (r_y_ok) begin
                    w_new_row = r_y_row;
                    w_row_wen = 1'b1;
                end
                if (w_data_ge && (w_diff < C_COLS_B)) begin
                    w_new_col = w_diff[COL_BITS-1:0];
                    w_col_wen = 1'b1;
                end
            end
            ST_ERASE: w_do_erase = 1'b1;
            default:  w_state = ST_NORMAL;
        endcase

        if (w_do_erase) begin
            w_char_wen  = 1'b1;
            w_char_out  = 8'h20;
            w_wr_row    = w_src_row;
            w_wr_col    = w_src_col;
            w_er_screen = w_src_screen;
            w_er_row    = (w_src_col == C_COL_LAST) ? w_src_row + 1'b1 : w_src_row;
            w_er_col    = (w_src_col == C_COL_LAST) ? '0 : w_src_col + 1'b1;
            w_state     = w_src_last ? ST_NORMAL : ST_ERASE;
        end

        // Holding ready low for the final sweep cycle lines ready up with the
        // cycle after the last write.
        w_ready = !w_accept && (r_state != ST_ERASE) && (w_state != ST_ERASE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_NORMAL;
            r_ready     <= 1'b0;
            r_new_row   <= '0;
            r_new_col   <= '0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_char_out  <= '0;
            r_row_wen   <= 1'b0;
            r_col_wen   <= 1'b0;
            r_char_wen  <= 1'b0;
            r_scroll    <= 1'b0;
            r_er_row    <= '0;
            r_er_col    <= '0;
            r_er_screen <= 1'b0;
            r_y_row     <= '0;
            r_y_ok      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ready     <= w_ready;
            r_new_row   <= w_new_row;
            r_new_col   <= w_new_col;
            r_wr_row    <= w_wr_row;
            r_wr_col    <= w_wr_col;
            r_char_out  <= w_char_out;
            r_row_wen   <= w_row_wen;
            r_col_wen   <= w_col_wen;
            r_char_wen  <= w_char_wen;
            r_scroll    <= w_scroll;
            r_er_row    <= w_er_row;
            r_er_col    <= w_er_col;
            r_er_screen <= w_er_screen;
            r_y_row     <= w_y_row;
            r_y_ok      <= w_y_ok;
        end
    end

    assign bus.ready    = r_ready;
    assign bus.new_row  = r_new_row;
    assign bus.row_wen  = r_row_wen;
    assign bus.new_col  = r_new_col;
    assign bus.col_wen  = r_col_wen;
    assign bus.wr_row   = r_wr_row;
    assign bus.wr_col   = r_wr_col;
    assign bus.char_out = r_char_out;
    assign bus.char_wen = r_char_wen;
    assign bus.scroll   = r_scroll;

endmodule

`default_nettype wire

// File: tb/tb_cursor_command_decoder.sv
// ============================================================================
// Module      : tb_cursor_command_decoder
// Description : Scoreboard bench for cursor_command_decoder with a cursor
//               register model closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cursor_command_decoder;

    typedef struct packed {
        logic       rw;
        logic [4:0] nr;
        logic       cw;
        logic [6:0] nc;
        logic       chw;
        logic [4:0] wr;
        logic [6:0] wc;
        logic [7:0] ch;
        logic       sc;
    } out_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic ignore = 1'b0;
    int   tests = 0;
    int   fails = 0;
    out_t exp_q[$];
    logic [4:0] m_row;
    logic [6:0] m_col;

    cursor_command_decoder_if #(.ROW_BITS(5), .COL_BITS(7)) bus ();

    cursor_command_decoder #(.ROWS(24), .COLS(80), .ROW_BITS(5), .COL_BITS(7)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Row and column cursor registers fed back into the decoder.
    always @(posedge clk) begin
        if (clr) begin
            m_row <= '0;
            m_col <= '0;
        end else begin
            if (bus.row_wen) m_row <= bus.new_row;
            if (bus.col_wen) m_col <= bus.new_col;
        end
    end
    assign bus.cur_row = m_row;
    assign bus.cur_col = m_col;

    function automatic void push(logic rw, logic [4:0] nr, logic cw, logic [6:0] nc,
                                 logic chw, logic [4:0] wr, logic [6:0] wc,
                                 logic [7:0] ch, logic sc);
        out_t e;
        e.rw = rw; e.nr = nr; e.cw = cw; e.nc = nc;
        e.chw = chw; e.wr = wr; e.wc = wc; e.ch = ch; e.sc = sc;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_row(logic [4:0] r);
        push(1, r, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic void exp_col(logic [6:0] c);
        push(0, 0, 1, c, 0, 0, 0, 0, 0);
    endfunction
    function automatic void exp_rc(logic [4:0] r, logic [6:0] c);
        push(1, r, 1, c, 0, 0, 0, 0, 0);
    endfunction
    function automatic void exp_chr(logic [4:0] r, logic [6:0] c, logic [7:0] ch);
        push(0, 0, 0, 0, 1, r, c, ch, 0);
    endfunction
    function automatic void exp_chr_mv(logic [4:0] r, logic [6:0] c, logic [7:0] ch);
        push(0, 0, 1, c + 7'd1, 1, r, c, ch, 0);
    endfunction

    // Monitor: any pulse pops one expected record.
    always @(negedge clk) begin
        if (!clr && !ignore &&
            (bus.row_wen || bus.col_wen || bus.char_wen || bus.scroll)) begin
            out_t o;
            o.rw  = bus.row_wen;
            o.nr  = bus.row_wen  ? bus.new_row  : 5'd0;
            o.cw  = bus.col_wen;
            o.nc  = bus.col_wen  ? bus.new_col  : 7'd0;
            o.chw = bus.char_wen;
            o.wr  = bus.char_wen ? bus.wr_row   : 5'd0;
            o.wc  = bus.char_wen ? bus.wr_col   : 7'd0;
            o.ch  = bus.char_wen ? bus.char_out : 8'd0;
            o.sc  = bus.scroll;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output got=%h expected=none", o);
            end else begin
                out_t e;
                e = exp_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL output got=%h expected=%h (rw nr cw nc chw wr wc ch sc)", o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            check("ready_timeout", 32'(bus.ready), 32'd1);
        end else begin
            bus.data  = b;
            bus.valid = 1'b1;
            @(posedge clk);
            #1;
            bus.valid = 1'b0;
            check("ready_low_after_accept", 32'(bus.ready), 32'd0);
        end
    endtask

    task automatic esc_y(input logic [7:0] rb, input logic [7:0] cb);
        send(8'h1B);
        send(8'h59);
        send(rb);
        send(cb);
    endtask

    initial begin
        int cnt;
        bus.data  = 8'h00;
        bus.valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_pulses", {28'd0, bus.row_wen, bus.col_wen, bus.char_wen, bus.scroll}, 32'd0);
        check("reset_new_row", 32'(bus.new_row), 32'd0);
        check("reset_char_out", 32'(bus.char_out), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(bus.ready), 32'd1);

        // Printables at origin
        exp_chr_mv(0, 0, 8'h41); send(8'h41);
        exp_chr_mv(0, 1, 8'h42); send(8'h42);

        // Last column: write, no move
        exp_rc(0, 79);           esc_y(8'h20, 8'h6F);
        exp_chr(0, 79, 8'h78);   send(8'h78);

        // Tabs and backspace
        exp_rc(0, 3);  esc_y(8'h20, 8'h23);
        exp_col(8);    send(8'h09);
        exp_rc(0, 73); esc_y(8'h20, 8'h69);
        exp_col(74);   send(8'h09);
        exp_rc(0, 0);  esc_y(8'h20, 8'h20);
        send(8'h08);

        // Line feed, scroll, carriage return
        exp_rc(22, 0); esc_y(8'h36, 8'h20);
        exp_row(23);   send(8'h0A);
        push(0, 0, 0, 0, 0, 0, 0, 0, 1); send(8'h0A);
        exp_col(0);    send(8'h0D);

        // Direct addressing with out-of-range axes
        exp_rc(5, 10); esc_y(8'h25, 8'h2A);
        exp_col(10);   esc_y(8'h40, 8'h2A);
        exp_row(5);    esc_y(8'h25, 8'h7F);

        // Relative moves and home
        exp_row(4);    send(8'h1B); send(8'h41);
        exp_row(5);    send(8'h1B); send(8'h42);
        exp_col(11);   send(8'h1B); send(8'h43);
        exp_col(10);   send(8'h1B); send(8'h44);
        exp_rc(0, 0);  send(8'h1B); send(8'h48);

        // Erase to end of line from (3,75)
        exp_rc(3, 75); esc_y(8'h23, 8'h6B);
        for (int c = 75; c < 80; c++) exp_chr(3, 7'(c), 8'h20);
        send(8'h1B); send(8'h4B);
        cnt = 0;
        while (!bus.ready && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("erase_line_ready_low_cycles", 32'(cnt), 32'd5);

        // Erase to end of screen from (22,78)
        exp_rc(22, 78); esc_y(8'h36, 8'h6E);
        exp_chr(22, 78, 8'h20);
        exp_chr(22, 79, 8'h20);
        for (int c = 0; c < 80; c++) exp_chr(23, 7'(c), 8'h20);
        send(8'h1B); send(8'h4A);

        // Erase from the bottom-right corner: single write
        exp_rc(23, 79); esc_y(8'h37, 8'h6F);
        exp_chr(23, 79, 8'h20);
        send(8'h1B); send(8'h4A);

        // Reset in the middle of a full-screen erase
        exp_rc(0, 0); send(8'h1B); send(8'h48);
        send(8'h1B);
        ignore = 1'b1;
        send(8'h4A);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("erase_running_before_clr", 32'(bus.char_wen), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_abort_pulses", {28'd0, bus.row_wen, bus.col_wen, bus.char_wen, bus.scroll}, 32'd0);
        check("clr_abort_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        clr    = 1'b0;
        ignore = 1'b0;

        // Unknown escape, then normal printing resumes
        send(8'h1B); send(8'h5A);
        exp_chr_mv(0, 0, 8'h41); send(8'h41);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cursor_command_decoder.md
Name: cursor_command_decoder

Overview:
- Upstream stage of the two cursor position registers (row and column): consumes received terminal bytes and decides every cursor move.
- Drives the registers' ipos/wen pairs and reads their opos values back as cur_row/cur_col.
- Also issues character writes to the screen buffer (printables and VT52 erase commands) and a scroll request.

Parameters:
- ROWS, 24, number of screen rows.
- COLS, 80, number of screen columns (must be ≥ 9).
- ROW_BITS, 5, row index width.
- COL_BITS, 7, column index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- data  in  8  received byte.
- valid  in  1  data valid.
- ready  out  1  byte accepted on the edge where valid & ready.
- cur_row  in  ROW_BITS  current row from the row cursor register.
- cur_col  in  COL_BITS  current column from the column cursor register.
- new_row  out  ROW_BITS  row cursor ipos.
- row_wen  out  1  row cursor wen, 1-cycle pulse.
- new_col  out  COL_BITS  column cursor ipos.
- col_wen  out  1  column cursor wen, 1-cycle pulse.
- wr_row  out  ROW_BITS  screen write row.
- wr_col  out  COL_BITS  screen write column.
- char_out  out  8  screen write data.
- char_wen  out  1  screen write strobe, 1-cycle pulse.
- scroll  out  1  scroll-up request, 1-cycle pulse.

Behaviour:
- Reset and output timing
  - During clr: state NORMAL; ready=0; all wen/strobe/scroll outputs = 0; new_row, new_col, wr_row, wr_col, char_out = 0.
  - ready=1 in the first cycle after clr deasserts.
  - clr mid-erase aborts the erase immediately.
  - All outputs are registered. A byte accepted in cycle N produces its pulses in cycle N+1.
  - ready=0 in cycle N+1, so the cursor registers have updated before the next byte is accepted. Peak throughput is 1 byte per 2 cycles.
  - valid is ignored while ready=0.
- NORMAL state
  - 0x20–0x7E: char_wen, char_out=data, wr_row/wr_col=cur_row/cur_col. If cur_col<COLS-1 then new_col=cur_col+1 and col_wen; at the last column the cursor does not move (next char overwrites).
  - 0x0D: new_col=0, col_wen.
  - 0x0A: if cur_row<ROWS-1 then new_row=cur_row+1 and row_wen; else scroll pulse and no row_wen.
  - 0x08: if cur_col>0 then new_col=cur_col-1 and col_wen; else nothing.
  - 0x09: if cur_col<COLS-8 then new_col=(cur_col & ~7)+8; else if cur_col<COLS-1 then cur_col+1; else nothing.
  - 0x1B: go to ESC. Any other byte is ignored.
- ESC state (next byte, then return to NORMAL unless noted)
  - 'A': row-1 if >0.
  - 'B': row+1 if <ROWS-1; never scrolls.
  - 'C': col+1 if <COLS-1.
  - 'D': col-1 if >0.
  - 'H': new_row=0, new_col=0, both wens.
  - 'Y': go to YROW.
  - 'J': go to ERASE, mode screen.
  - 'K': go to ERASE, mode line.
  - Anything else, including 0x1B: ignored.
- YROW / YCOL (direct cursor addressing)
  - YROW: latch r=data-0x20, then go to YCOL.
  - YCOL: c=data-0x20.
  - On YCOL acceptance, pulses in the same cycle:
    - row_wen/new_row=r only if 0x20≤row byte and r<ROWS;
    - col_wen/new_col=c only if 0x20≤data and c<COLS.
  - An out-of-range coordinate leaves that axis unchanged.
- ERASE state
  - ready=0 throughout; cursor never moves.
  - One char_wen per cycle with char_out=0x20, starting at cur_row/cur_col captured on entry.
  - Line mode: columns cur_col..COLS-1 of the captured row.
  - Screen mode: the line-mode span, then every column of rows captured_row+1..ROWS-1 in row-major order.
  - After the last write, return to NORMAL; ready=1 the cycle after the last char_wen.
  - At cursor position (ROWS-1, COLS-1): exactly one write.

Test Plan:
- Reset then "AB" at (0,0): char_wen with 'A' at (0,0) and col_wen new_col=1; then 'B' at (0,1), new_col=2; ready low the cycle after each accept.
- Printable at col 79: char written at col 79, no col_wen. TAB at col 3 → 8. TAB at col 73 → 74. BS at col 0 → no pulse.
- LF at row 22 → row_wen new_row=23. LF at row 23 → scroll=1, no row_wen. CR → new_col=0.
- ESC Y 0x25 0x2A → new_row=5, new_col=10, both wens same cycle. ESC Y 0x40 0x2A → row unchanged, col=10. ESC Y 0x25 0x7F → row=5, col unchanged.
- ESC K at (3,75) → 5 writes of 0x20 at (3,75..79), ready=0 for 5 cycles. ESC J at (22,78) → 2+80=82 writes ending at (23,79).
- clr asserted mid ESC J → all pulses 0 next cycle, state NORMAL. ESC then 'Z' → no output; next 'A' prints normally.
